// File: rtl/store_buffer.sv
// In-order doubleword store buffer between the MEM stage and Data_Memory.
// Optional macro STBUF_FWD_EN: forward buffered stores to loads; when undefined, matching loads stall.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_fwd_data,
    output logic              ld_stall,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memorywrite,
    output logic              mem_memoryread,
    output logic              sb_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [PTR_W:0]    count;

    logic ld_req, match_any, ld_port, push, drain;
`ifdef STBUF_FWD_EN
    logic [DATA_W-1:0] match_data;
`endif

    assign st_ready = (count != FULL);
    assign sb_empty = (count == '0);
    assign push     = st_valid & st_ready;
    // A load presented while reset is held must not claim the memory port.
    assign ld_req   = ld_valid & ~reset;

    // Walk entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        match_any = 1'b0;
`ifdef STBUF_FWD_EN
        match_data = '0;
`endif
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (((PTR_W+1)'(k) < count) &&
                (addr_q[idx][ADDR_W-1:3] == ld_addr[ADDR_W-1:3])) begin
                match_any = 1'b1;
`ifdef STBUF_FWD_EN
                match_data = data_q[idx];
`endif
            end
        end
    end

`ifdef STBUF_FWD_EN
    assign ld_hit      = ld_req & match_any;
    assign ld_fwd_data = ld_hit ? match_data : '0;
    assign ld_stall    = 1'b0;
`else
    assign ld_hit      = 1'b0;
    assign ld_fwd_data = '0;
    assign ld_stall    = ld_req & match_any;
`endif

    assign ld_port = ld_req & ~match_any;
    assign drain   = (count != '0) & ~ld_port;

    always_comb begin
        mem_memoryread  = ld_port;
        mem_memorywrite = drain;
        mem_address     = '0;
        mem_write_data  = '0;
        if (ld_port) begin
            mem_address = ld_addr;
        end else if (drain) begin
            mem_address    = addr_q[head];
            mem_write_data = data_q[head];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= st_addr;
            data_q[tail] <= st_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + PTR_W'(1);
            if (drain)
                head <= head + PTR_W'(1);
            case ({push, drain})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (st_valid)
                assert (st_addr[2:0] == 3'b000);
            if (ld_valid)
                assert (ld_addr[2:0] == 3'b000);
        end
    end
`endif

endmodule
